// File: rtl/fnd_pkg.sv
// Shared constants, state type and segment lookup for the FND scan driver.
// Optional build macro FND_LEADING_ZERO_BLANK_EN is consumed by fnd_scan_driver.
package fnd_pkg;

    localparam int         FND_DIGITS    = 4;
    localparam logic [7:0] FND_SEG_BLANK = 8'h00;
    localparam logic [3:0] COM_OFF       = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } bcd_state_e;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fnd_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with input saturation.
// One start strobe yields a done pulse VALUE_W+1 cycles later.
module fnd_bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [VALUE_W-1:0] i_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_bcd
);

    localparam int                 CNT_W = $clog2(VALUE_W + 1);
    localparam logic [VALUE_W-1:0] SAT   = VALUE_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(VALUE_W - 1);

    bcd_state_e         state_q;
    logic [VALUE_W-1:0] bin_q;
    logic [15:0]        bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    logic [VALUE_W-1:0]    sat_d;
    logic [15:0]           adj_d;
    logic [16+VALUE_W-1:0] sh_d;

    always_comb begin
        sat_d = (i_value > SAT) ? SAT : i_value;
        adj_d = bcd_q;
        for (int i = 0; i < FND_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        sh_d = {adj_d, bin_q} << 1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        bin_q   <= sat_d;
                        bcd_q   <= '0;
                        cnt_q   <= LAST;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= sh_d[16+VALUE_W-1:VALUE_W];
                    bin_q <= sh_d[VALUE_W-1:0];
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                COMMIT: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = bcd_q;

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit seven-segment scan driver with atomic BCD display register.
// Define FND_LEADING_ZERO_BLANK_EN to blank leading zero digits 3..1.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int VALUE_W = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_digitSel,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_load,
    input  logic [3:0]         i_dp,
    output logic               o_busy,
    output logic [3:0]         o_fndCom,
    output logic [7:0]         o_fndFont
);

    logic        conv_done;
    logic [15:0] conv_bcd;

    fnd_bin2bcd_seq #(
        .VALUE_W(VALUE_W),
        .MAX_VAL(MAX_VAL)
    ) u_bcd (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_load),
        .i_value(i_value),
        .o_busy (o_busy),
        .o_done (conv_done),
        .o_bcd  (conv_bcd)
    );

    logic [15:0] disp_q, disp_d;
    logic [1:0]  prev_q, prev_d;
    logic [3:0]  com_q, com_d;
    logic [7:0]  font_q, font_d;
    logic [6:0]  seg;

`ifdef FND_LEADING_ZERO_BLANK_EN
    logic [3:0] blank_q, blank_d;
`endif

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;
        prev_d = i_digitSel;
        seg    = seg7(disp_q[4*i_digitSel +: 4]);
`ifdef FND_LEADING_ZERO_BLANK_EN
        blank_d = blank_q;
        if (conv_done) begin
            blank_d[3] = (conv_bcd[15:12] == 4'd0);
            blank_d[2] = blank_d[3] && (conv_bcd[11:8] == 4'd0);
            blank_d[1] = blank_d[2] && (conv_bcd[7:4] == 4'd0);
            blank_d[0] = 1'b0;
        end
        if (blank_q[i_digitSel]) begin
            seg = 7'h00;
        end
`endif
        // A digit change gets one dark cycle to hide common switching.
        if (i_digitSel != prev_q) begin
            com_d  = COM_OFF;
            font_d = FND_SEG_BLANK;
        end else begin
            com_d  = ~(4'b0001 << i_digitSel);
            font_d = {i_dp[i_digitSel], seg};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_q  <= '0;
            prev_q  <= '0;
            com_q   <= COM_OFF;
            font_q  <= FND_SEG_BLANK;
`ifdef FND_LEADING_ZERO_BLANK_EN
            blank_q <= 4'b1110;
`endif
        end else begin
            disp_q  <= disp_d;
            prev_q  <= prev_d;
            com_q   <= com_d;
            font_q  <= font_d;
`ifdef FND_LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign o_fndCom  = com_q;
    assign o_fndFont = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: decimal model plus directed cases.
module tb_fnd_scan_driver;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp = 4'd0;
    logic        busy;
    logic [3:0]  com;
    logic [7:0]  font;

    int n_checks = 0;
    int n_fail = 0;

    fnd_scan_driver #(.VALUE_W(14), .MAX_VAL(9999)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_digitSel(sel),
        .i_value   (value),
        .i_load    (load),
        .i_dp      (dp),
        .o_busy    (busy),
        .o_fndCom  (com),
        .o_fndFont (font)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int s);
        int p = 1;
        for (int i = 0; i < s; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int s);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (s > 0 && v < pow10(s)) return 7'h00;
`endif
        return SEG_TAB[(v / pow10(s)) % 10];
    endfunction

    // Model: displayed decimal value, pending value, cycles left busy.
    int         m_disp;
    int         m_pend;
    int         m_cnt;
    logic [1:0] m_prev;
    logic [3:0] e_com;
    logic [7:0] e_font;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_disp <= 0;
            m_pend <= 0;
            m_cnt  <= 0;
            m_prev <= 2'd0;
            e_com  <= 4'hF;
            e_font <= 8'h00;
        end else begin
            if (sel != m_prev) begin
                e_com  <= 4'hF;
                e_font <= 8'h00;
            end else begin
                e_com  <= ~(4'b0001 << sel);
                e_font <= {dp[sel], model_seg(m_disp, int'(sel))};
            end
            m_prev <= sel;
            if (m_cnt == 0) begin
                if (load) begin
                    m_pend <= (int'(value) > 9999) ? 9999 : int'(value);
                    m_cnt  <= 15;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_disp <= m_pend;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_busy", int'(busy), int'(m_cnt != 0));
            chk("model_com", int'(com), int'(e_com));
            chk("model_font", int'(font), int'(e_font));
        end
    end

    task automatic do_load(input int v);
        @(negedge clk);
        value = 14'(v);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("busy_timeout", n, 0);
    endtask

    task automatic show(input logic [1:0] s, input int ecom, input int efont);
        bit changed;
        @(negedge clk);
        changed = (s != sel);
        sel = s;
        @(negedge clk);
        if (changed) chk("ghost_blank", int'(com), 'hF);
        @(negedge clk);
        chk("show_com", int'(com), ecom);
        chk("show_font", int'(font), efont);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk("rst_com", int'(com), 'hF);
        chk("rst_font", int'(font), 'h00);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_com", int'(com), 'hE);
        chk("post_rst_font", int'(font), 'h3F);
        chk("post_rst_busy", int'(busy), 0);

        do_load(1234);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 15);
        show(2'd3, 'h7, 'h06);
        show(2'd2, 'hB, 'h5B);
        show(2'd1, 'hD, 'h4F);
        show(2'd0, 'hE, 'h66);

        do_load(16383);
        wait_idle();
        show(2'd3, 'h7, 'h6F);
        show(2'd0, 'hE, 'h6F);
        do_load(10000);
        wait_idle();
        show(2'd2, 'hB, 'h6F);
        show(2'd1, 'hD, 'h6F);
        do_load(9999);
        wait_idle();
        show(2'd0, 'hE, 'h6F);

        do_load(1234);
        repeat (3) @(negedge clk);
        value = 14'd5678;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle();
        show(2'd3, 'h7, 'h06);
        show(2'd0, 'hE, 'h66);
        do_load(5678);
        wait_idle();
        show(2'd3, 'h7, 'h6D);
        show(2'd0, 'hE, 'h7F);

        dp = 4'b0100;
        do_load(1234);
        wait_idle();
        show(2'd2, 'hB, 'hDB);
        show(2'd1, 'hD, 'h4F);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) chk("scan_fast_com", int'(com), 'hF);
            sel = sel + 2'd1;
        end
        dp = 4'd0;

        do_load(42);
        wait_idle();
`ifdef FND_LEADING_ZERO_BLANK_EN
        show(2'd3, 'h7, 'h00);
        show(2'd2, 'hB, 'h00);
`else
        show(2'd3, 'h7, 'h3F);
        show(2'd2, 'hB, 'h3F);
`endif
        show(2'd1, 'hD, 'h66);
        show(2'd0, 'hE, 'h5B);

        do_load(0);
        wait_idle();
`ifdef FND_LEADING_ZERO_BLANK_EN
        show(2'd1, 'hD, 'h00);
`else
        show(2'd1, 'hD, 'h3F);
`endif
        show(2'd0, 'hE, 'h3F);

        show(2'd0, 'hE, 'h3F);
        do_load(9876);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_busy", int'(busy), 0);
        chk("midrst_com", int'(com), 'hF);
        @(negedge clk);
        rst_n = 1'b1;
        show(2'd0, 'hE, 'h3F);
`ifdef FND_LEADING_ZERO_BLANK_EN
        show(2'd3, 'h7, 'h00);
`else
        show(2'd3, 'h7, 'h3F);
`endif

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0: value = 14'd9999;
                1: value = 14'd10000;
                2: value = 14'd0;
                default: value = 14'($urandom_range(0, 16383));
            endcase
            if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom);
        end
        load = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
